// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Purpose  : Clocked stand-in for the external SRAM seen by the memory stage.
//            Holds a DEPTH x 32 word array, answers reads after READ_CYCLES
//            edges on the shared SRAM_DQ bus and commits writes after
//            WRITE_CYCLES edges, so ready/freeze logic upstream sees
//            realistic multi-cycle accesses.
// Ports    : clk        - system clock, all state changes on rising edge
//            rst        - asynchronous reset, active-low
//            SRAM_WE_N  - write enable, active-low (1 = read)
//            SRAM_ADDR  - word address, index = SRAM_ADDR mod DEPTH
//            SRAM_DQ    - bidirectional data, driven only while rd_valid=1
//            rd_valid   - responder is driving valid read data on SRAM_DQ
//            wr_commit  - one-cycle pulse after a write reaches the array
//            err        - sticky protocol error flag
// Options  : SRAM_RESP_ERRCHK_EN - when defined, err flags aborted writes
//            and out-of-range write addresses; otherwise err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sram_responder #(
   parameter int ADDR_W       = 17,
   parameter int DEPTH        = 2048,
   parameter int READ_CYCLES  = 4,
   parameter int WRITE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SRAM_WE_N,
   input  logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [31:0]       SRAM_DQ,
   output logic              rd_valid,
   output logic              wr_commit,
   output logic              err
);

   localparam int         c_IDX_W   = $clog2(DEPTH);
   // cnt starts at 1 on the start edge, so the latch/commit edge is the one
   // where cnt still holds CYCLES-1 (giving data at E0+CYCLES-1).
   localparam logic [3:0] c_RD_LAST = 4'(READ_CYCLES - 1);
   localparam logic [3:0] c_WR_LAST = 4'(WRITE_CYCLES - 1);
   localparam bit         c_RD_ONE  = (READ_CYCLES == 1);
   localparam bit         c_WR_ONE  = (WRITE_CYCLES == 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_READ_WAIT  = 3'd1,
      S_READ_DRIVE = 3'd2,
      S_WRITE_WAIT = 3'd3,
      S_WRITE_DONE = 3'd4
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [ADDR_W-1:0]   r_prev_addr;
   logic                r_prev_we;
   logic                r_rd_valid;
   logic                r_wr_commit;
   logic [31:0]         r_rd_data;
   logic [31:0]         r_mem [DEPTH];

   logic [c_IDX_W-1:0]  w_idx;
   logic                w_start;
   logic                w_rd_latch;
   logic                w_mem_we;

   assign w_idx = SRAM_ADDR[c_IDX_W-1:0];

   // A new access always wins over a pending latch/commit of the old one.
   always_comb begin
      w_start    = (r_state == S_IDLE) || (SRAM_ADDR != r_prev_addr) ||
                   (SRAM_WE_N != r_prev_we);
      w_rd_latch = 1'b0;
      w_mem_we   = 1'b0;
      if (w_start) begin
         w_rd_latch = SRAM_WE_N & c_RD_ONE;
         w_mem_we   = ~SRAM_WE_N & c_WR_ONE;
      end else begin
         w_rd_latch = (r_state == S_READ_WAIT)  && (r_cnt == c_RD_LAST);
         w_mem_we   = (r_state == S_WRITE_WAIT) && (r_cnt == c_WR_LAST);
      end
   end

   // Array and read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= SRAM_DQ;
      end
      if (w_rd_latch) begin
         r_rd_data <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_prev_addr <= '0;
         r_prev_we   <= 1'b1;
         r_rd_valid  <= 1'b0;
         r_wr_commit <= 1'b0;
      end else begin
         r_prev_addr <= SRAM_ADDR;
         r_prev_we   <= SRAM_WE_N;
         r_wr_commit <= w_mem_we;
         if (w_start) begin
            r_cnt      <= 4'd1;
            r_rd_valid <= w_rd_latch;
            if (!SRAM_WE_N) begin
               r_state <= c_WR_ONE ? S_WRITE_DONE : S_WRITE_WAIT;
            end else begin
               r_state <= c_RD_ONE ? S_READ_DRIVE : S_READ_WAIT;
            end
         end else begin
            case (r_state)
               S_READ_WAIT: begin
                  r_cnt <= r_cnt + 4'd1;
                  if (w_rd_latch) begin
                     r_state    <= S_READ_DRIVE;
                     r_rd_valid <= 1'b1;
                  end
               end
               S_WRITE_WAIT: begin
                  r_cnt <= r_cnt + 4'd1;
                  if (w_mem_we) begin
                     r_state <= S_WRITE_DONE;
                  end
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   // WE_N gating keeps the bus free the moment the initiator turns it
   // around, before the access-start edge has cleared rd_valid.
   assign SRAM_DQ   = (r_rd_valid && SRAM_WE_N) ? r_rd_data : 32'bz;
   assign rd_valid  = r_rd_valid;
   assign wr_commit = r_wr_commit;

`ifdef SRAM_RESP_ERRCHK_EN
   localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);

   logic r_err;
   logic w_err_set;

   // An address can only reach DEPTH when DEPTH < 2**ADDR_W, so the range
   // test needs no separate guard.
   always_comb begin
      w_err_set = w_start &&
                  ((r_state == S_WRITE_WAIT) ||
                   (!SRAM_WE_N && ({1'b0, SRAM_ADDR} >= c_DEPTH_EXT)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire
